dsc_sn_decoder: RTL
===================

Name: dsc_sn_decoder

Overview:
- Receiving end of the deterministic stochastic computing (DSC) serial datapath.
- Consumes the product bitstream produced by the cascaded SNG/AND stage and counts its ones over one frame.
- The frame ends on a full-length count or, optionally, on the early-shutoff indication.
- Presents the binary result in a held output register with a valid/ready handshake, so downstream logic can take results at its own pace.

Parameters:
- SNG_WIDTH, 10, width of each SNG input operand.
- NUM_INPUTS, 3, number of multiplied stochastic inputs.
- OUT_WIDTH, NUM_INPUTS*SNG_WIDTH, result width; frame length is 2^OUT_WIDTH valid beats.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  pulse that begins a frame; accepted only in IDLE.
- sn_in  in  1  stochastic product bit.
- sn_valid  in  1  sn_in/frame_end are meaningful this cycle.
- frame_end  in  1  early-shutoff/last-beat marker, qualified by sn_valid.
- z  out  OUT_WIDTH  count of ones in the last frame.
- z_valid  out  1  z holds an unconsumed result.
- z_ready  in  1  downstream accepts z.
- sat  out  1  result saturated; valid with z.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, async): FSM=IDLE; accumulator, beat counter, z, z_valid, sat, busy all 0. Reset mid-frame discards the partial frame; no result is produced.
- State IDLE:
  - busy=0.
  - start=1 clears accumulator and beat counter, then goes to ACCUM next cycle.
  - sn_valid is ignored in IDLE, including on the start cycle.
- State ACCUM:
  - busy=1.
  - Each cycle with sn_valid=1: beat counter +1; if sn_in=1, accumulator +1.
  - Cycles with sn_valid=0 change nothing; gaps are allowed anywhere.
  - start is ignored.
  - Frame terminates on the valid beat that is beat number 2^OUT_WIDTH (counter is OUT_WIDTH+1 bits), or on frame_end (see Optional Feature).
  - The terminating beat's sn_in is included in the count.
- Saturation:
  - Accumulator is OUT_WIDTH+1 bits internally.
  - If final count > 2^OUT_WIDTH-1: z=2^OUT_WIDTH-1 and sat=1; otherwise z=count and sat=0.
- Termination:
  - The cycle after the terminating beat is sampled: z and sat are registered, z_valid=1, FSM goes to HOLD.
  - Latency from terminating beat to z_valid is 1 cycle.
- State HOLD:
  - busy=1; z, sat and z_valid are stable.
  - sn_valid is ignored; start is ignored unless z_ready=1 in the same cycle.
  - Handshake z_valid&z_ready: next cycle z_valid=0 (z and sat keep their values).
    - If start=1 in that same cycle: FSM goes to ACCUM with cleared counters.
    - Otherwise: FSM goes to IDLE.
- z_ready while z_valid=0 has no effect.
- No results are queued. Beats arriving outside ACCUM are dropped by design; the upstream must not stream until the decoder is busy in ACCUM.

Optional Feature:
- Macro: DSC_DEC_EARLY_SHUTOFF_EN.
- Defined: in ACCUM, sn_valid=1 with frame_end=1 terminates the frame on that beat (that beat's sn_in counted). Full-length termination still applies. Both on the same beat: one termination, one result.
- Undefined: frame_end is ignored entirely; the frame always runs 2^OUT_WIDTH valid beats.

Test Plan (SNG_WIDTH=2, NUM_INPUTS=2 → OUT_WIDTH=4, frame=16 beats):
- Full frame: start; 16 consecutive valid beats with ones on beats 1,4,7,9,15; frame_end=0; z_ready=1 → z_valid high 1 cycle after beat 16, z=5, sat=0, then IDLE (busy=0).
- Saturation with gaps: start; 16 valid beats all sn_in=1, with sn_valid=0 gaps after beats 3 and 10 → z=15, sat=1; gaps do not advance the count.
- Early shutoff, macro defined: start; 6 valid beats with ones on beats 2,5,6, frame_end=1 on beat 6 → z=3, z_valid 1 cycle after beat 6. Same stimulus, macro undefined → no result at beat 6; frame continues to beat 16.
- Backpressure: complete a frame with z=9 and hold z_ready=0 for 10 cycles, pulsing start and streaming beats → z=9 and z_valid=1 stable, busy=1, no new frame. Then raise z_ready together with start → z_valid drops next cycle, FSM in ACCUM, next frame counts from 0.
- Reset mid-frame: assert rst=0 after 7 beats in ACCUM → asynchronously z=0, z_valid=0, sat=0, busy=0. After release, a fresh 16-beat frame with 2 ones → z=2.
- IDLE robustness: stream valid beats of sn_in=1 with no start, and pulse z_ready → no state change, z_valid=0, busy=0.

Source files
------------

// File: rtl/dsc_sn_decoder.sv
// Stochastic-number decoder: counts ones of the DSC product bitstream over one frame
// and holds the saturated binary result. Optional macro DSC_DEC_EARLY_SHUTOFF_EN lets frame_end end a frame early.
module dsc_sn_decoder #(
  parameter int SNG_WIDTH  = 10,
  parameter int NUM_INPUTS = 3,
  parameter int OUT_WIDTH  = NUM_INPUTS * SNG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sn_in,
  input  logic                 sn_valid,
  input  logic                 frame_end,
  output logic [OUT_WIDTH-1:0] z,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic                 sat,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Last beat of a full frame is beat number 2^OUT_WIDTH, i.e. counter value 2^OUT_WIDTH-1.
  localparam logic [OUT_WIDTH:0] LAST_BEAT = {1'b0, {OUT_WIDTH{1'b1}}};

  state_t               state_q, state_d;
  logic [OUT_WIDTH:0]   acc_q;
  logic [OUT_WIDTH:0]   beat_q;
  logic [OUT_WIDTH:0]   acc_next;
  logic [OUT_WIDTH-1:0] z_q;
  logic                 z_valid_q;
  logic                 sat_q;
  logic                 early;
  logic                 clr;
  logic                 beat_en;
  logic                 term;
  logic                 take;

`ifdef DSC_DEC_EARLY_SHUTOFF_EN
  assign early = frame_end;
`else
  assign early = 1'b0;
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

  assign acc_next = acc_q + {{OUT_WIDTH{1'b0}}, sn_in};

  // Handshake: z_valid rises the cycle after the terminating beat and stays high with z/sat
  // stable until a cycle where z_valid & z_ready; z_valid is low from the next cycle on.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    beat_en = 1'b0;
    term    = 1'b0;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (sn_valid) begin
          beat_en = 1'b1;
          if (beat_q == LAST_BEAT || early) begin
            term    = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (z_valid_q && z_ready) begin
          take = 1'b1;
          if (start) begin
            clr     = 1'b1;
            state_d = S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      beat_q    <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        acc_q  <= '0;
        beat_q <= '0;
      end else if (beat_en) begin
        acc_q  <= acc_next;
        beat_q <= beat_q + 1'b1;
      end
      // Only an all-ones full frame can exceed the output range.
      if (term) begin
        z_q       <= acc_next[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : acc_next[OUT_WIDTH-1:0];
        sat_q     <= acc_next[OUT_WIDTH];
        z_valid_q <= 1'b1;
      end else if (take) begin
        z_valid_q <= 1'b0;
      end
    end
  end

  assign z         = z_q;
  assign z_valid   = z_valid_q;
  assign sat       = sat_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule
